// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns PCF, issues instruction-memory requests and
// fills the IF/ID pipeline register, tolerating wait states, stalls and redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        FetchBusyF
);

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_DISCARD = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] buf_r;
    logic [31:0] instr_d_r;
    logic [31:0] pc_d_r;
    logic [31:0] pc_plus4_d_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;
    logic [31:0] word_s;
    logic        redirect_s;
    logic        stall_s;
    logic        avail_s;
    logic        take_s;

    // Redirect decode and availability of an instruction this cycle
    always_comb begin
        pc_plus4_s = pc_r + 32'd4;
        redirect_s = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
        case (PCSrcE)
            2'b01:   target_s = PCTargetE;
            2'b10:   target_s = {ALUResultE[31:1], 1'b0};
            default: target_s = pc_plus4_s;
        endcase
        stall_s = StallF || StallD;
        avail_s = ((state_r == S_FETCH) && imem_ready) || (state_r == S_HOLD);
        if (state_r == S_HOLD) begin
            word_s = buf_r;
        end else begin
            word_s = imem_rdata;
        end
        // A word is consumed only when both PC and IF/ID are free to advance
        take_s = avail_s && !redirect_s && !stall_s;
    end

    // Next-state and next-PC selection
    always_comb begin
        state_nxt_s = state_r;
        if (redirect_s) begin
            if (imem_ready || (state_r == S_HOLD)) begin
                state_nxt_s = S_FETCH;
            end else begin
                state_nxt_s = S_DISCARD;
            end
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (imem_ready && stall_s) begin
                        state_nxt_s = S_HOLD;
                    end else begin
                        state_nxt_s = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (imem_ready) begin
                        state_nxt_s = S_FETCH;
                    end else begin
                        state_nxt_s = S_DISCARD;
                    end
                end
                S_HOLD: begin
                    if (stall_s) begin
                        state_nxt_s = S_HOLD;
                    end else begin
                        state_nxt_s = S_FETCH;
                    end
                end
                default: state_nxt_s = S_FETCH;
            endcase
        end

        if (redirect_s) begin
            pc_nxt_s = target_s;
        end else if (take_s) begin
            pc_nxt_s = pc_plus4_s;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // PC, FSM, hold buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_FETCH;
            pc_r         <= RESET_PC;
            buf_r        <= 32'd0;
            instr_d_r    <= NOP_INSTR;
            pc_d_r       <= 32'd0;
            pc_plus4_d_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            if ((state_r == S_FETCH) && imem_ready && stall_s && !redirect_s) begin
                buf_r <= imem_rdata;
            end else begin
                buf_r <= buf_r;
            end
            if (FlushD) begin
                instr_d_r    <= NOP_INSTR;
                pc_d_r       <= 32'd0;
                pc_plus4_d_r <= 32'd0;
            end else if (StallD) begin
                instr_d_r    <= instr_d_r;
                pc_d_r       <= pc_d_r;
                pc_plus4_d_r <= pc_plus4_d_r;
            end else if (take_s) begin
                instr_d_r    <= word_s;
                pc_d_r       <= pc_r;
                pc_plus4_d_r <= pc_plus4_s;
            end else begin
                instr_d_r    <= NOP_INSTR;
                pc_d_r       <= 32'd0;
                pc_plus4_d_r <= 32'd0;
            end
        end
    end

    assign imem_req   = (state_r != S_HOLD);
    assign imem_addr  = pc_r;
    assign InstrD     = instr_d_r;
    assign PCD        = pc_d_r;
    assign PCPlus4D   = pc_plus4_d_r;
    assign FetchBusyF = !avail_s && !redirect_s;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, StallF, StallD, FlushD, imem_ready;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE, ALUResultE, imem_rdata;
    logic        imem_req, FetchBusyF;
    logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;

    int checks = 0;
    int errors = 0;
    bit synced = 1'b0;

    // model of the pipeline as seen from outside
    logic [31:0] m_pc, m_buf, m_instr, m_pcd, m_pcp4;
    bit          m_bufv, m_stale;
    // memory: remembers the address a multi-cycle request was issued for
    bit          mem_busy;
    logic [31:0] mem_lat;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FetchBusyF(FetchBusyF)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // one clock: compare registered outputs, drive inputs, compare busy, advance model
    task automatic cycle(input bit rst, input bit sf, input bit sd, input bit fd,
                         input logic [1:0] src, input logic [31:0] tgt,
                         input logic [31:0] alu, input bit rdy);
        bit          redir, avail, take, req_v;
        logic [31:0] target, w, addr_v;
        logic [31:0] n_pc, n_buf, n_instr, n_pcd, n_pcp4;
        bit          n_bufv, n_stale;
        if (synced) begin
            chk("InstrD", InstrD, m_instr);
            chk("PCD", PCD, m_pcd);
            chk("PCPlus4D", PCPlus4D, m_pcp4);
            chk("imem_req", {31'd0, imem_req}, {31'd0, !m_bufv});
            chk("imem_addr", imem_addr, m_pc);
        end
        rst_n = rst; StallF = sf; StallD = sd; FlushD = fd;
        PCSrcE = src; PCTargetE = tgt; ALUResultE = alu;
        imem_ready = rdy && imem_req;
        imem_rdata = imem_ready ? word(mem_busy ? mem_lat : imem_addr) : $urandom;
        #1;
        req_v  = imem_req;
        addr_v = imem_addr;
        redir  = (src == 2'b01) || (src == 2'b10);
        target = (src == 2'b10) ? {alu[31:1], 1'b0} : tgt;
        avail  = m_bufv || (imem_ready && !m_stale);
        if (synced && rst) chk("FetchBusyF", {31'd0, FetchBusyF}, {31'd0, !avail && !redir});

        n_pc = m_pc; n_buf = m_buf; n_bufv = m_bufv; n_stale = m_stale;
        n_instr = m_instr; n_pcd = m_pcd; n_pcp4 = m_pcp4;
        if (!rst) begin
            n_pc = 32'd0; n_buf = 32'd0; n_bufv = 1'b0; n_stale = 1'b0;
            n_instr = NOP; n_pcd = 32'd0; n_pcp4 = 32'd0;
        end else begin
            take = avail && !redir && !sf && !sd;
            w = m_bufv ? m_buf : imem_rdata;
            if (fd) begin
                n_instr = NOP; n_pcd = 32'd0; n_pcp4 = 32'd0;
            end else if (sd) begin
                n_instr = m_instr;
            end else if (take) begin
                n_instr = w; n_pcd = m_pc; n_pcp4 = m_pc + 32'd4;
            end else begin
                n_instr = NOP; n_pcd = 32'd0; n_pcp4 = 32'd0;
            end
            n_pc = redir ? target : (take ? m_pc + 32'd4 : m_pc);
            if (redir) begin
                n_bufv = 1'b0;
                n_stale = !imem_ready && !m_bufv;
            end else if (m_stale) begin
                n_stale = !imem_ready;
            end else if (m_bufv) begin
                n_bufv = sf || sd;
            end else if (imem_ready && (sf || sd)) begin
                n_bufv = 1'b1;
                n_buf = imem_rdata;
            end
        end

        @(posedge clk);
        m_pc = n_pc; m_buf = n_buf; m_bufv = n_bufv; m_stale = n_stale;
        m_instr = n_instr; m_pcd = n_pcd; m_pcp4 = n_pcp4;
        if (!rst) mem_busy = 1'b0;
        else if (imem_ready) mem_busy = 1'b0;
        else if (req_v && !mem_busy) begin
            mem_busy = 1'b1;
            mem_lat = addr_v;
        end
        if (!rst) synced = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 2'b00;
        PCTargetE = 32'd0; ALUResultE = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
        mem_busy = 1'b0; mem_lat = 32'd0;
        @(negedge clk);
        cycle(0, 0, 0, 0, 2'b00, 32'd0, 32'd0, 0);
        cycle(0, 0, 0, 0, 2'b00, 32'd0, 32'd0, 0);
        chk("reset_InstrD", InstrD, NOP);
        chk("reset_PCD", PCD, 32'd0);
        chk("reset_addr", imem_addr, 32'd0);
        chk("reset_req", {31'd0, imem_req}, 32'd1);

        // zero-wait streaming
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 2'b00, 32'd0, 32'd0, 1);
        chk("stream_PCD", PCD, 32'd8);
        chk("stream_InstrD", InstrD, word(32'd8));
        chk("stream_PCPlus4D", PCPlus4D, 32'd12);
        chk("stream_addr", imem_addr, 32'd12);

        // three wait states at 12
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 2'b00, 32'd0, 32'd0, 0);
        chk("wait_addr", imem_addr, 32'd12);
        chk("wait_InstrD", InstrD, NOP);

        // word at 12 arrives under stall, held two cycles, then released
        cycle(1, 1, 1, 0, 2'b00, 32'd0, 32'd0, 1);
        cycle(1, 1, 1, 0, 2'b00, 32'd0, 32'd0, 1);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_InstrD", InstrD, NOP);
        cycle(1, 0, 0, 0, 2'b00, 32'd0, 32'd0, 1);
        chk("release_InstrD", InstrD, word(32'd12));
        chk("release_addr", imem_addr, 32'd16);

        // redirect to 0x100 while 16 is outstanding; late word must be dropped
        cycle(1, 0, 0, 0, 2'b00, 32'd0, 32'd0, 0);
        cycle(1, 0, 0, 1, 2'b01, 32'h100, 32'd0, 0);
        chk("redir_addr", imem_addr, 32'h100);
        cycle(1, 0, 0, 0, 2'b00, 32'd0, 32'd0, 1);
        chk("discard_InstrD", InstrD, NOP);
        cycle(1, 0, 0, 0, 2'b00, 32'd0, 32'd0, 1);
        chk("target_InstrD", InstrD, word(32'h100));
        chk("target_PCD", PCD, 32'h100);

        // jalr with flush
        cycle(1, 0, 0, 1, 2'b10, 32'd0, 32'h205, 1);
        chk("jalr_addr", imem_addr, 32'h204);
        chk("jalr_InstrD", InstrD, NOP);

        // reset during a pending request
        cycle(1, 0, 0, 0, 2'b00, 32'd0, 32'd0, 0);
        cycle(0, 0, 0, 0, 2'b00, 32'd0, 32'd0, 0);
        chk("rst_mid_addr", imem_addr, 32'd0);
        chk("rst_mid_InstrD", InstrD, NOP);
        cycle(1, 0, 0, 0, 2'b00, 32'd0, 32'd0, 1);
        chk("rst_mid_first", InstrD, word(32'd0));

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [1:0] src;
            src = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            cycle($urandom_range(0, 149) != 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, src,
                  {22'd0, 8'($urandom), 2'b00}, $urandom,
                  $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
